// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes shared with the control decoder, plus stage occupancy states
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_BAD = 4'b1111;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU producing result, zero, signed overflow and illegal-code flags
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);
  logic [WIDTH-1:0] sum, diff;
  logic lt;
  always_comb begin
    sum = a + b;
    diff = a - b;
    lt = $signed(a) < $signed(b);
    illegal = !(ctrl inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR});
    result = ctrl == ALU_AND ? a & b :
             ctrl == ALU_OR  ? a | b :
             ctrl == ALU_ADD ? sum :
             ctrl == ALU_SUB ? diff :
             ctrl == ALU_SLT ? {{(WIDTH-1){1'b0}}, lt} :
             ctrl == ALU_NOR ? ~(a | b) : '0;
    ovf = ctrl == ALU_ADD ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]) :
          ctrl == ALU_SUB ? (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]) : 1'b0;
    zero = result == '0;
  end
endmodule

// File: rtl/alu_stage.sv
// alu_stage: registered ALU execute stage with output + skid buffer and valid/ready handshakes
module alu_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ctrl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic             err_sticky,
  input  logic             err_clr
);
  localparam int EW = WIDTH + 3;
  occ_e state_q, state_d;
  logic [EW-1:0] out_q, out_d, skid_q, skid_d, core_e;
  logic [WIDTH-1:0] c_res;
  logic c_zero, c_ovf, c_ill;
  logic in_ready_q, err_q, err_d, acc, otx;
  alu_core #(.WIDTH(WIDTH)) u_core (
    .ctrl(in_ctrl),
    .a(in_a),
    .b(in_b),
    .result(c_res),
    .zero(c_zero),
    .ovf(c_ovf),
    .illegal(c_ill)
  );
  assign core_e = {c_res, c_zero, c_ovf, c_ill};
  always_comb begin
    acc = in_valid && in_ready_q;
    otx = state_q != EMPTY && out_ready;
    state_d = state_q;
    out_d = out_q;
    skid_d = skid_q;
    case (state_q)
      EMPTY: if (acc) begin
        state_d = ONE;
        out_d = core_e;
      end
      ONE: if (acc && otx) out_d = core_e;
      else if (acc) begin
        state_d = FULL;
        skid_d = core_e;
      end else if (otx) state_d = EMPTY;
      FULL: if (otx) begin
        state_d = ONE;
        out_d = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    err_d = (acc && c_ill) || (err_q && !err_clr);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      out_q <= '0;
      skid_q <= '0;
      in_ready_q <= 1'b1;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      skid_q <= skid_d;
      in_ready_q <= state_d != FULL;
      err_q <= err_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = state_q != EMPTY;
  assign {out_result, out_zero, out_ovf, out_illegal} = out_q;
  assign err_sticky = err_q;
endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: directed plan plus randomized traffic checked against a queue-based reference model
module tb_alu_stage;
  typedef struct {logic [31:0] r; logic z, o, i;} exp_t;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0, err_clr = 0;
  logic [3:0] in_ctrl = 0;
  logic [31:0] in_a = 0, in_b = 0, out_result;
  logic in_ready, out_valid, out_zero, out_ovf, out_illegal, err_sticky;
  int n_chk = 0, n_fail = 0;
  exp_t q[$];
  logic m_err = 0, m_rst = 1, last_acc = 0;
  localparam longint MAXS = 64'sh7FFF_FFFF;
  localparam longint MINS = -64'sh8000_0000;
  always #5 clk = ~clk;
  alu_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_ovf(out_ovf), .out_illegal(out_illegal), .err_sticky(err_sticky),
    .err_clr(err_clr)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a)), sb = longint'($signed(b));
    longint ua = longint'(a), ub = longint'(b), r;
    exp_t e;
    e.o = 0;
    e.i = 0;
    case (c)
      4'b0000: r = ua & ub;
      4'b0001: r = ua | ub;
      4'b0010: begin r = ua + ub; e.o = (sa + sb > MAXS) || (sa + sb < MINS); end
      4'b0110: begin r = ua - ub; e.o = (sa - sb > MAXS) || (sa - sb < MINS); end
      4'b0111: r = sa < sb ? 1 : 0;
      4'b1100: r = ~(ua | ub);
      default: begin r = 0; e.i = 1; end
    endcase
    e.r = r[31:0];
    e.z = e.r == 0;
    return e;
  endfunction
  task automatic step(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic ordy, input logic clr, input logic rst);
    exp_t e;
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("err_sticky", 64'(err_sticky), 64'(m_err));
    if (q.size() > 0) begin
      check("out_result", 64'(out_result), 64'(q[0].r));
      check("out_zero", 64'(out_zero), 64'(q[0].z));
      check("out_ovf", 64'(out_ovf), 64'(q[0].o));
      check("out_illegal", 64'(out_illegal), 64'(q[0].i));
    end else if (m_rst) begin
      check("rst_result", 64'(out_result), 64'd0);
      check("rst_flags", 64'({out_zero, out_ovf, out_illegal}), 64'd0);
    end
    in_valid = v; in_ctrl = c; in_a = a; in_b = b;
    out_ready = ordy; err_clr = clr; reset = rst;
    last_acc = !rst && v && q.size() < 2;
    m_rst = rst;
    if (rst) begin
      q.delete();
      m_err = 0;
    end else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (last_acc) begin
        e = ref_alu(c, a, b);
        q.push_back(e);
      end
      m_err = (last_acc && e.i) ? 1'b1 : clr ? 1'b0 : m_err;
    end
  endtask
  task automatic idle(input logic ordy, input logic clr);
    step(0, 4'b0000, 0, 0, ordy, clr, 0);
  endtask
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic ordy, input logic clr);
    for (int k = 0; k < 20; k++) begin
      step(1, c, a, b, ordy, clr, 0);
      if (last_acc) return;
    end
    check("send_timeout", 64'd0, 64'd1);
  endtask
  function automatic logic [31:0] pick_op();
    logic [31:0] corner[5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    return $urandom_range(0, 2) == 0 ? corner[$urandom_range(0, 4)] : $urandom;
  endfunction
  initial begin
    logic [3:0] codes[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111, 4'b0000};
    logic [3:0] c;
    repeat (2) @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 1);
    send(4'b0010, 32'h7FFF_FFFF, 32'h1, 1, 0);
    idle(1, 0);
    idle(1, 0);
    send(4'b0110, 5, 5, 1, 0);
    send(4'b0111, 32'hFFFF_FFFF, 1, 1, 0);
    send(4'b1100, 0, 0, 1, 0);
    idle(1, 0);
    idle(1, 0);
    send(4'b0000, 32'hF0, 32'h3C, 0, 0);
    send(4'b0001, 32'hF0, 32'h0F, 0, 0);
    for (int k = 0; k < 2; k++) begin
      step(1, 4'b0010, 1, 1, 0, 0, 0);
      check("held", 64'(last_acc), 64'd0);
    end
    send(4'b0010, 1, 1, 1, 0);
    repeat (4) idle(1, 0);
    send(4'b1111, 7, 9, 1, 0);
    repeat (3) idle(1, 0);
    send(4'b1111, 7, 9, 1, 1);
    idle(1, 0);
    idle(1, 1);
    idle(1, 0);
    send(4'b0000, 32'hFF, 32'h0F, 0, 0);
    send(4'b1111, 1, 2, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1);
    repeat (3) idle(1, 0);
    for (int k = 0; k < 400; k++) begin
      c = $urandom_range(0, 3) == 0 ? 4'($urandom) : codes[$urandom_range(0, 7)];
      step($urandom_range(0, 3) != 0, c, pick_op(), pick_op(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
    end
    repeat (4) idle(1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_stage.md
Name: alu_stage

Overview:
Registered ALU execute stage, directly downstream of the ALU control decoder. Consumes the 4-bit ALU control code plus two operands and produces result, zero, overflow and illegal-op flags. Uses valid/ready handshakes on both sides. A 2-entry output buffer (output register plus skid register) gives full throughput and a registered in_ready.

Parameters:
WIDTH, 32, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream presents an operation
in_ready  output  1  stage can accept an operation (registered)
in_ctrl  input  4  ALU control code from the ALU control decoder
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
out_valid  output  1  result available
out_ready  input  1  downstream accepts the result
out_result  output  WIDTH  operation result
out_zero  output  1  out_result == 0
out_ovf  output  1  signed overflow (ADD/SUB only)
out_illegal  output  1  in_ctrl was not a legal code
err_sticky  output  1  latched illegal-op indicator
err_clr  input  1  clears err_sticky

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Control codes:
  - 0000 AND: a&b
  - 0001 OR: a|b
  - 0010 ADD: a+b, modulo 2^WIDTH
  - 0110 SUB: a-b, modulo 2^WIDTH
  - 0111 SLT: signed a<b gives 1, else 0, zero-extended
  - 1100 NOR: ~(a|b)
  - any other code, including 1111: result 0, illegal=1, ovf=0
- ovf: set on ADD when the operand signs match and the result sign differs. Set on SUB when the operand signs differ and the result sign differs from a. Zero for all other ops.
- zero: computed from the final result, including illegal ops (result 0 gives zero=1).
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Storage: output register (OUT) and skid register (SKID), each holding {result, zero, ovf, illegal} plus a valid bit.
- States by occupancy: EMPTY (neither valid), ONE (OUT valid only), FULL (both valid).
- Transitions per cycle:
  - EMPTY + input accept -> ONE; result visible on out_* the next cycle (latency 1).
  - ONE + accept + out transfer -> ONE with new data.
  - ONE + accept, no out transfer -> FULL; new op goes to SKID.
  - ONE + out transfer, no accept -> EMPTY.
  - FULL + out transfer -> ONE; SKID moves to OUT.
  - No input accepted in FULL.
- in_ready = !SKID.valid, registered. It deasserts the cycle after FULL is entered and reasserts the cycle after FULL is left.
- out_* data is stable while out_valid && !out_ready. Order is strictly FIFO.
- in_valid while in_ready=0: no effect; upstream holds its data.
- err_sticky sets on the cycle an illegal op is accepted at the input. It clears on err_clr. If set and clear occur in the same cycle, set wins.
- Reset values: out_valid=0, SKID.valid=0, in_ready=1, out_result=0, out_zero=0, out_ovf=0, out_illegal=0, err_sticky=0.
- Reset mid-operation discards all buffered ops; no output transfer occurs in the reset cycle.

Decomposition:
- Shared package alu_pkg: constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100, ALU_BAD=4'b1111. The ALU control decoder uses the same constants.
- One combinational sub-module, alu_core: inputs ctrl, a, b; outputs result, zero, ovf, illegal.
- alu_stage instantiates alu_core on the input side and holds the handshake/buffer logic.

Test Plan:
- ADD a=0x7FFFFFFF, b=0x00000001, out_ready=1 -> one cycle later out_result=0x80000000, ovf=1, zero=0, illegal=0.
- SUB a=5, b=5, then SLT a=0xFFFFFFFF, b=1, then NOR a=0, b=0, issued back-to-back -> results 0 (zero=1), 1, 0xFFFFFFFF on consecutive cycles, in_ready constantly 1.
- out_ready=0; issue AND(0xF0,0x3C), OR(0xF0,0x0F), then ADD(1,1) -> first two accepted, in_ready=0 the following cycle, third held. Raise out_ready -> outputs 0x30, 0xFF, 0x2 in order, each data stable while stalled.
- ctrl=1111 with a=7, b=9 -> out_result=0, zero=1, illegal=1, err_sticky=1 until err_clr. A second illegal op issued in the same cycle as err_clr leaves err_sticky=1.
- Fill to FULL, assert reset for 1 cycle -> out_valid=0, in_ready=1, err_sticky=0. Both buffered results never appear.
